// File: rtl/alu_serial_slice.sv
// Digit-serial 181-style ALU: evaluates one DIGIT-bit slice per clock, LSB first,
// with the inter-digit carry held in a register. Visible results update only on completion.
//   state | meaning
//   IDLE  | ready for a command
//   RUN   | one digit evaluated per clock
//   DONE  | result held until out_ready
module alu_serial_slice #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             eq,
  output logic             zero,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic [3:0]       s_r;
  logic             m_r, carry_r;

  logic [DIGIT-1:0] a_d, b_d, p_d, g_d, dig_f;
  logic [DIGIT:0]   sum_d;
  logic [WIDTH-1:0] res_full;
  logic             last;

  assign last = (k == KLAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // One 181-style digit; acc keeps finished low digits so res_full is the complete word on the last digit.
  always_comb begin
    a_d   = a_r[k*DIGIT +: DIGIT];
    b_d   = b_r[k*DIGIT +: DIGIT];
    p_d   = a_d | (b_d & {DIGIT{s_r[0]}}) | (~b_d & {DIGIT{s_r[1]}});
    g_d   = (a_d & ~b_d & {DIGIT{s_r[2]}}) | (a_d & b_d & {DIGIT{s_r[3]}});
    sum_d = {1'b0, p_d} + {1'b0, g_d} + {{DIGIT{1'b0}}, carry_r};
    dig_f = m_r ? ~(p_d ^ g_d) : sum_d[DIGIT-1:0];
    res_full = acc;
    res_full[k*DIGIT +: DIGIT] = dig_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      m_r     <= 1'b0;
      carry_r <= 1'b0;
      acc     <= '0;
      f       <= '0;
      cout    <= 1'b0;
      eq      <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            s_r     <= s;
            m_r     <= m;
            carry_r <= cin;
            k       <= '0;
          end
        end
        RUN: begin
          acc     <= res_full;
          carry_r <= sum_d[DIGIT];
          k       <= last ? '0 : k + KW'(1);
          if (last) begin
            f    <= res_full;
            cout <= ~m_r & sum_d[DIGIT];
            eq   <= &res_full;
            zero <= ~|res_full;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_serial_slice.md
Name: alu_serial_slice

Overview:
- Parametrised, multi-cycle successor to the 4-bit 181-style ALU slice.
- Operates on WIDTH-bit operands by iterating one DIGIT-bit 181-style slice LSB-first, chaining the carry between digits in a register.
- Provides the same 16 logic and 16 arithmetic functions at any width, plus a valid/ready handshake and result flags.
- Sits between the operand/instruction register file and the writeback path.

Parameters:
- WIDTH, 16, operand/result width; must be a positive multiple of DIGIT.
- DIGIT, 4, bits processed per clock; NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/command presented.
- in_ready  out  1  block can accept a command.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  4  function select S3..S0.
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- cin  in  1  active-high carry-in (arithmetic only).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- cout  out  1  carry out of the MSB digit (arithmetic); 0 in logic mode.
- eq  out  1  f is all ones (A=B compare output when s=0110, m=0, cin=0).
- zero  out  1  f == 0.
- busy  out  1  state is not IDLE.

Behaviour:
- Per-bit function definitions:
  - P = A | (S0 & B) | (S1 & ~B)
  - G = (S2 & A & ~B) | (S3 & A & B)
- Logic mode (m=1): F = ~(P ^ G), bitwise. No carry; cout = 0.
- Arithmetic mode (m=0): F = P + G + cin, mod 2^WIDTH. cout is the carry out of bit WIDTH-1.
- Serial evaluation: digit k computes F[kD+D-1:kD] = P_k + G_k + carry_reg. carry_reg is loaded with cin at acceptance and updated with the digit carry-out each RUN cycle. The final result must be bit-identical to the full-width formula.
- On acceptance, a, b, s, m and cin are captured into internal registers. Input ports may change freely after acceptance.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. When in_valid is high at an edge, capture operands, set digit index to 0, go to RUN.
  - RUN: in_ready = 0. Each edge computes digit k, writes its slice of the result register, updates carry_reg and increments k. At the edge with k = NDIG-1, latch cout, eq and zero, and go to DONE.
  - DONE: out_valid = 1. f, cout, eq, zero and out_valid hold stable until out_ready is sampled high, then go to IDLE.
- Latency: acceptance at edge T0; out_valid is first high after edge T0+NDIG.
- Throughput: one operation per NDIG+2 cycles minimum (no overlap).
- in_valid during RUN or DONE is ignored and nothing is captured. The command source must hold in_valid until in_ready.
- out_ready while not in DONE has no effect.
- NDIG = 1 is legal: RUN lasts a single cycle.
- Reset (any state, including mid-RUN or DONE with a pending result) returns to IDLE on the next edge and discards the operation.
  - Reset values: out_valid = 0, in_ready = 1, busy = 0, f = 0, cout = 0, eq = 0, zero = 0, carry_reg = 0, digit index = 0.
- f, cout, eq and zero change only at the final RUN edge or at reset. They are not updated digit-by-digit on the visible outputs.

Test Plan:
- Add, carry across digits (WIDTH=16): m=0, s=1001, a=0x1234, b=0x0FFF, cin=0 -> f=0x2233, cout=0, zero=0. out_valid rises exactly 4 edges after acceptance.
- Full-width ripple: m=0, s=1001, a=0xFFFF, b=0x0001, cin=0 -> f=0x0000, cout=1, zero=1, eq=0.
- Subtract and compare:
  - m=0, s=0110, a=0x0005, b=0x0003, cin=1 -> f=0x0002, cout=1.
  - Same with a=b=0x5A5A, cin=0 -> f=0xFFFF, eq=1, cout=0.
- Logic XOR: m=1, s=0110, a=0xF0F0, b=0xFF00, cin=1 -> f=0x0FF0, cout=0 (cin ignored).
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE and drive a second command -> f and flags stable, in_ready=0, second command not captured.
  - Then out_ready=1 -> IDLE next edge, and the second command is accepted on the following edge.
- Reset mid-operation: assert rst during the 2nd RUN cycle -> next edge IDLE, out_valid=0, in_ready=1, f=0, all flags 0. A new add then completes with the correct result.
